// File: rtl/ps2_rx_buffered_pkg.sv
// Shared types and helpers for the buffered PS/2 receiver: FSM state encoding,
// frame framing constants and the odd-parity generator.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic PS2_START_BIT = 1'b0;
  localparam logic PS2_STOP_BIT  = 1'b1;

  // Parity bit that makes the total count of ones over data+parity odd.
  function automatic logic odd_parity_bit(input logic [31:0] data, input int nbits);
    logic p;
    p = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/ps2_rx_buffered_if.sv
// Consumer-side bundle of the PS/2 receiver: byte stream handshake, occupancy,
// activity and error pulses. master = receiver, slave = scan-code decoder.
interface ps2_rx_buffered_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int FILL_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [FILL_W-1:0]    fill;
  logic                 busy;
  logic                 err_frame;
  logic                 err_parity;
  logic                 err_timeout;
  logic                 err_overflow;

  modport master (
    output rx_data, rx_valid, fill, busy,
    output err_frame, err_parity, err_timeout, err_overflow,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, fill, busy,
    input  err_frame, err_parity, err_timeout, err_overflow,
    output rx_ready
  );
endinterface

// File: rtl/ps2_rx_buffered_fifo.sv
// Show-ahead byte FIFO for the PS/2 receiver: head entry is visible on o_data
// straight from storage, and reads as zero while the FIFO is empty.
module ps2_byte_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int FW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_push,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_pop,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [FW-1:0]        o_fill
);

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr;
  logic [AW-1:0]        r_rd;
  logic [FW-1:0]        r_fill;
  logic                 w_do_pop;
  logic                 w_do_push;

  assign o_empty   = (r_fill == '0);
  assign o_full    = (r_fill == FW'(FIFO_DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_fill    = r_fill;
  assign o_data    = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fill <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      if (w_do_push && !w_do_pop)      r_fill <= r_fill + FW'(1);
      else if (!w_do_push && w_do_pop) r_fill <= r_fill - FW'(1);
    end
  end

endmodule

// File: rtl/ps2_rx_buffered.sv
// PS/2 device-to-host receiver: pin synchronisers, falling-edge detect, frame
// FSM with timeout, and a show-ahead byte FIFO. Optional ps2c stability
// filter is enabled by defining PS2_GLITCH_FILTER_EN.
module ps2_rx_buffered
  import ps2_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ps2c,
  input  logic               ps2d,
  ps2_rx_buffered_if.master  rx
);

  localparam int CNT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int TW     = $clog2(TIMEOUT_CYCLES);
  localparam int FILL_W = $clog2(FIFO_DEPTH + 1);

  if (SYNC_STAGES < 2 || FILTER_LEN < 1 || TIMEOUT_CYCLES < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("ps2_rx_buffered: illegal parameter combination");
  end

  logic [SYNC_STAGES-1:0] r_sync_c;
  logic [SYNC_STAGES-1:0] r_sync_d;
  logic                   r_prev_c;
  logic                   w_sync_c;
  logic                   w_level_c;
  logic                   w_d;
  logic                   w_fall;

  ps2_state_t             r_state, w_next_state;
  logic [CNT_W-1:0]       r_count, w_next_count;
  logic [DATA_BITS-1:0]   r_shift, w_next_shift;
  logic                   r_parity, w_next_parity;
  logic [TW-1:0]          r_timer, w_next_timer;
  logic                   w_push;
  logic                   w_err_frame;
  logic                   w_err_parity;
  logic                   w_err_timeout;

  logic [DATA_BITS-1:0]   w_fifo_data;
  logic                   w_full;
  logic                   w_empty;
  logic [FILL_W-1:0]      w_fill;

  // Synchronisers idle high so leaving reset never fabricates an edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync_c <= '1;
      r_sync_d <= '1;
    end else begin
      r_sync_c <= {r_sync_c[SYNC_STAGES-2:0], ps2c};
      r_sync_d <= {r_sync_d[SYNC_STAGES-2:0], ps2d};
    end
  end

  assign w_sync_c = r_sync_c[SYNC_STAGES-1];
  assign w_d      = r_sync_d[SYNC_STAGES-1];

`ifdef PS2_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);
  logic [FCW-1:0] r_filt_cnt;
  logic           r_filt_c;

  // The filtered level follows only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_filt_cnt <= '0;
      r_filt_c   <= 1'b1;
    end else if (w_sync_c == r_filt_c) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FCW'(FILTER_LEN - 1)) begin
      r_filt_cnt <= '0;
      r_filt_c   <= w_sync_c;
    end else begin
      r_filt_cnt <= r_filt_cnt + FCW'(1);
    end
  end

  assign w_level_c = r_filt_c;
`else
  assign w_level_c = w_sync_c;
`endif

  always_ff @(posedge clk) begin
    if (!reset) r_prev_c <= 1'b1;
    else        r_prev_c <= w_level_c;
  end

  assign w_fall = r_prev_c & ~w_level_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_timer  <= '0;
    end else begin
      r_state  <= w_next_state;
      r_count  <= w_next_count;
      r_shift  <= w_next_shift;
      r_parity <= w_next_parity;
      r_timer  <= w_next_timer;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_count  = r_count;
    w_next_shift  = r_shift;
    w_next_parity = r_parity;
    w_next_timer  = r_timer;
    w_push        = 1'b0;
    w_err_frame   = 1'b0;
    w_err_parity  = 1'b0;
    w_err_timeout = 1'b0;

    if (r_state == IDLE || w_fall) w_next_timer = '0;
    else                           w_next_timer = r_timer + TW'(1);

    case (r_state)
      IDLE: begin
        if (w_fall) begin
          if (w_d == PS2_START_BIT) begin
            w_next_state = DATA;
            w_next_count = '0;
            w_next_shift = '0;
          end else begin
            w_err_frame = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_fall) begin
          w_next_shift[r_count] = w_d;
          if (r_count == CNT_W'(DATA_BITS - 1)) begin
            w_next_state = PARITY;
            w_next_count = '0;
          end else begin
            w_next_count = r_count + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (w_fall) begin
          w_next_parity = w_d;
          w_next_state  = STOP;
        end
      end
      STOP: begin
        if (w_fall) begin
          w_next_state = IDLE;
          if (w_d != PS2_STOP_BIT)                                  w_err_frame  = 1'b1;
          else if (r_parity != odd_parity_bit(32'(r_shift), DATA_BITS)) w_err_parity = 1'b1;
          else                                                      w_push       = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase

    // A stalled frame is abandoned; a fall in the same cycle keeps it alive.
    if (r_state != IDLE && !w_fall && r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
      w_next_state  = IDLE;
      w_next_count  = '0;
      w_next_shift  = '0;
      w_next_timer  = '0;
      w_err_timeout = 1'b1;
    end
  end

  ps2_byte_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (rx.rx_ready),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_fill  (w_fill)
  );

  assign rx.rx_data      = w_fifo_data;
  assign rx.rx_valid     = ~w_empty;
  assign rx.fill         = w_fill;
  assign rx.busy         = (r_state != IDLE);
  assign rx.err_frame    = w_err_frame;
  assign rx.err_parity   = w_err_parity;
  assign rx.err_timeout  = w_err_timeout;
  assign rx.err_overflow = w_push & w_full & ~(rx.rx_ready & ~w_empty);

endmodule
